cla_divider_seq: RTL and testbench
==================================

# cla_divider_seq

Multi-cycle unsigned 32-bit divider for the RV32M `divu`/`remu` path that reuses one 32-bit `cla` adder as its trial subtractor. It runs restoring division at one quotient bit per cycle. It sits beside the single-cycle ALU and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- None. Operand width is fixed at 32 to match `cla`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `i_flush`  in  1  abort the in-flight operation (pipeline flush).
- `i_valid`  in  1  request valid.
- `o_in_ready`  out  1  block can accept a request.
- `i_dividend`  in  32  unsigned dividend.
- `i_divisor`  in  32  unsigned divisor.
- `o_valid`  out  1  result valid.
- `i_out_ready`  in  1  consumer takes the result.
- `o_quotient`  out  32  quotient.
- `o_remainder`  out  32  remainder.
- `o_busy`  out  1  high in BUSY.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - `o_in_ready`=1.
  - On `i_valid`, latch the dividend into shift register `dq` and the divisor into `dvs`, clear `rem` and the counter `cnt`, then go to BUSY.
- BUSY, each cycle:
  - `shifted` = {`rem`[30:0], `dq`[31]}; `msb_out` = `rem`[31].
  - Drive `cla` with a=`shifted`, b=~`dvs`, cin=1.
  - Derive carry-out: c31 = sum[31]^a[31]^b[31]; cout = (a[31]&b[31]) | ((a[31]|b[31])&c31).
  - take = `msb_out` | cout.
  - `rem` ← take ? sum : `shifted`.
  - `dq` ← {`dq`[30:0], take}.
  - `cnt`++.
  - When `cnt`==31, copy the final `dq` to `o_quotient` and the final `rem` to `o_remainder` in the same edge, then go to DONE.
- DONE:
  - `o_valid`=1; outputs are held stable until `i_out_ready`.
  - On `i_out_ready`, return to IDLE.
  - No request is accepted in DONE; `o_in_ready`=0.
- Divide by zero needs no special case. The algorithm produces quotient 0xFFFFFFFF and remainder = dividend, which matches the RISC-V definition. The bench must check this.
- `i_flush`:
  - In any state, go to IDLE next edge and deassert `o_valid`.
  - A result pending in DONE is discarded.
  - Flush wins over a simultaneous `i_valid` or `i_out_ready`; nothing is accepted that cycle.
- `i_dividend`/`i_divisor` are sampled only on the accept edge. Later changes are ignored.

## Timing
- Reset value of every output:
  - `o_in_ready`=1
  - `o_valid`=0
  - `o_busy`=0
  - `o_quotient`=0
  - `o_remainder`=0
  - FSM in IDLE, `cnt`=0.
- Reset asserted mid-operation returns everything to these values immediately. No result is produced.
- The accept edge is E0. Iterations occur on edges E1..E32. `o_valid` is high starting in the cycle after E32.
- Accept to `o_valid` is 33 cycles. `o_busy` is high for exactly 32 cycles.
- Return to IDLE happens on the output handshake edge. `o_in_ready` is high the next cycle, giving a minimum 34-cycle issue interval.
- `o_quotient`/`o_remainder` are registered and change only on the E32 edge. There is no combinational path from inputs to outputs.
- `o_in_ready` and `o_valid` are functions of state only. They never depend combinationally on `i_valid` or `i_out_ready`.
- `cnt` is 5 bits. It wraps to 0 on the transition to DONE.

## Structure
- Package `cla_div_pkg`:
  - typedef enum `div_state_t` {IDLE, BUSY, DONE}
  - localparam `DIV_WIDTH`=32
  - localparam `DIV_CNT_W`=5
- One sub-module: a single instance of the existing `cla`. Nothing else is instantiated.
- Carry-out derivation stays inline in this block. `cla` is not modified.

## Test plan
- 100 / 7 → quotient 14, remainder 2. `o_valid` rises exactly 33 cycles after accept, and `o_busy` is high for 32 cycles.
- 0xDEADBEEF / 0 → quotient 0xFFFFFFFF, remainder 0xDEADBEEF.
- 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0. 0x80000000 / 0xFFFFFFFF → quotient 0, remainder 0x80000000. This exercises the `msb_out` and carry-out paths.
- Backpressure: hold `i_out_ready`=0 for 10 cycles in DONE, with `i_valid`=1 and new operands throughout.
  - Outputs stay stable and `o_in_ready` stays 0.
  - The second request is accepted only in the cycle after the handshake.
- Flush on the 10th BUSY cycle → IDLE next edge; `o_valid` never asserts. Flush in DONE together with `i_out_ready` → result dropped, IDLE next edge.
- Drop `rst_n` mid-BUSY, asynchronously between edges → all outputs at reset values before the next edge. A fresh 1000 / 33 afterwards gives quotient 30, remainder 10.

Source files
------------

// File: rtl/cla_div_pkg.sv
// Shared types and sizes for the sequential restoring divider.
package cla_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : cla_div_pkg

// File: rtl/cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained on group carry.
module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    // The top group's carry-out is not needed; callers rebuild it from sum[31].
    if (k < 7) begin : g_next
      assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B])
                    | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end
  end

  assign sum = p ^ c;

endmodule : cla

// File: rtl/cla_divider_seq.sv
// Unsigned 32-bit restoring divider (divu/remu), one quotient bit per cycle,
// using a single cla instance as the trial subtractor.
module cla_divider_seq
  import cla_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder,
  output logic                 o_busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. o_in_ready/o_valid are registered from state only, and i_flush
  // overrides any transfer in the same cycle.

  div_state_t           state;
  logic [DIV_WIDTH-1:0] dq;
  logic [DIV_WIDTH-1:0] dvs;
  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_CNT_W-1:0] cnt;

  logic [DIV_WIDTH-1:0] shifted;
  logic [DIV_WIDTH-1:0] trial_b;
  logic [DIV_WIDTH-1:0] cla_sum;
  logic [DIV_WIDTH-1:0] rem_next;
  logic [DIV_WIDTH-1:0] dq_next;
  logic                 msb_out;
  logic                 c31;
  logic                 cout;
  logic                 take;

  assign shifted = {rem[DIV_WIDTH-2:0], dq[DIV_WIDTH-1]};
  assign msb_out = rem[DIV_WIDTH-1];
  assign trial_b = ~dvs;

  cla u_cla (
    .a   (shifted),
    .b   (trial_b),
    .cin (1'b1),
    .sum (cla_sum)
  );

  // Recover the adder's carry-out; a carry means shifted >= dvs. A bit shifted
  // out of rem means the 33-bit partial remainder already exceeds dvs.
  assign c31      = cla_sum[DIV_WIDTH-1] ^ shifted[DIV_WIDTH-1] ^ trial_b[DIV_WIDTH-1];
  assign cout     = (shifted[DIV_WIDTH-1] & trial_b[DIV_WIDTH-1])
                  | ((shifted[DIV_WIDTH-1] | trial_b[DIV_WIDTH-1]) & c31);
  assign take     = msb_out | cout;
  assign rem_next = take ? cla_sum : shifted;
  assign dq_next  = {dq[DIV_WIDTH-2:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      o_in_ready  <= 1'b1;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (i_flush) begin
      state      <= IDLE;
      cnt        <= '0;
      o_in_ready <= 1'b1;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            dq         <= i_dividend;
            dvs        <= i_divisor;
            rem        <= '0;
            cnt        <= '0;
            state      <= BUSY;
            o_in_ready <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        BUSY: begin
          rem <= rem_next;
          dq  <= dq_next;
          cnt <= cnt + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
          if (cnt == {DIV_CNT_W{1'b1}}) begin
            o_quotient  <= dq_next;
            o_remainder <= rem_next;
            state       <= DONE;
            o_busy      <= 1'b0;
            o_valid     <= 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          o_in_ready <= 1'b1;
          o_valid    <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule : cla_divider_seq

// File: tb/tb_cla_divider_seq.sv
// Directed bench for cla_divider_seq: arithmetic corners, timing, backpressure,
// flush and asynchronous reset.
module tb_cla_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_in_ready;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_valid;
  logic        i_out_ready;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;

  int vectors;
  int miscompares;

  cla_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_busy      (o_busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request, then run until o_valid (bounded). Latency is
  // counted from the cycle the request is presented (accept cycle = 1).
  task automatic run_div(input logic [31:0] dd, input logic [31:0] dv,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int busy_n);
    int n;
    busy_n     = 0;
    i_valid    = 1'b1;
    i_dividend = dd;
    i_divisor  = dv;
    @(posedge clk); #1;
    n          = 1;
    i_valid    = 1'b0;
    i_dividend = 32'hA5A5_5A5A;
    i_divisor  = 32'h0000_0003;
    while (!o_valid && n < 100) begin
      if (o_busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    if (!o_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL run_div_timeout dd=%h dv=%h: o_valid still %b after %0d cycles, required 1",
               dd, dv, o_valid, n);
    end
    lat = n;
    q   = o_quotient;
    r   = o_remainder;
  endtask

  task automatic take_result();
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", o_in_ready); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy); end
    vectors++; if (o_quotient !== 32'h0) begin miscompares++; $display("FAIL reset_quotient got %h want 0", o_quotient); end
    vectors++; if (o_remainder !== 32'h0) begin miscompares++; $display("FAIL reset_remainder got %h want 0", o_remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset in_ready=%b busy=%b want 1/0", o_in_ready, o_busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q, r;
    int lat, bn;
    run_div(32'd100, 32'd7, q, r, lat, bn);
    vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL basic_quotient got %0d want 14", q); end
    vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL basic_remainder got %0d want 2", r); end
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL basic_latency got %0d want 33", lat); end
    vectors++; if (bn !== 32) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 32", bn); end
    vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL done_in_ready got %b want 0", o_in_ready); end
    take_result();
    vectors++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL handshake_idle valid=%b in_ready=%b want 0/1", o_valid, o_in_ready);
    end
  endtask

  task automatic test_corners();
    logic [31:0] q, r;
    int lat, bn;
    run_div(32'hDEAD_BEEF, 32'h0, q, r, lat, bn);
    vectors++; if (q !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_quotient got %h want ffffffff", q); end
    vectors++; if (r !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL div0_remainder got %h want deadbeef", r); end
    take_result();
    run_div(32'hFFFF_FFFF, 32'h1, q, r, lat, bn);
    vectors++; if (q !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div1_quotient got %h want ffffffff", q); end
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL div1_remainder got %h want 0", r); end
    take_result();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, lat, bn);
    vectors++; if (q !== 32'h0) begin miscompares++; $display("FAIL msb_quotient got %h want 0", q); end
    vectors++; if (r !== 32'h8000_0000) begin miscompares++; $display("FAIL msb_remainder got %h want 80000000", r); end
    take_result();
    run_div(32'h1234_5678, 32'h100, q, r, lat, bn);
    vectors++; if (q !== 32'h0012_3456) begin miscompares++; $display("FAIL shift_quotient got %h want 00123456", q); end
    vectors++; if (r !== 32'h78) begin miscompares++; $display("FAIL shift_remainder got %h want 78", r); end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    int lat, bn, n;
    run_div(32'd50, 32'd6, q, r, lat, bn);
    vectors++; if (q !== 32'd8 || r !== 32'd2) begin
      miscompares++; $display("FAIL bp_first_result got q=%0d r=%0d want 8/2", q, r);
    end
    i_valid    = 1'b1;
    i_dividend = 32'd1000;
    i_divisor  = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++; if (o_quotient !== 32'd8 || o_remainder !== 32'd2) begin
        miscompares++; $display("FAIL bp_hold cycle %0d q=%0d r=%0d want 8/2", i, o_quotient, o_remainder);
      end
      vectors++; if (o_in_ready !== 1'b0 || o_valid !== 1'b1) begin
        miscompares++; $display("FAIL bp_flags cycle %0d in_ready=%b valid=%b want 0/1", i, o_in_ready, o_valid);
      end
      i_dividend = i_dividend + 32'd1;
    end
    i_dividend  = 32'd1000;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    vectors++; if (o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_handshake in_ready=%b valid=%b busy=%b want 1/0/0", o_in_ready, o_valid, o_busy);
    end
    @(posedge clk); #1;
    i_valid    = 1'b0;
    i_dividend = 32'hFFFF_FFFF;
    i_divisor  = 32'd1;
    vectors++; if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_second_accept busy=%b in_ready=%b want 1/0", o_busy, o_in_ready);
    end
    n = 0;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
    vectors++; if (o_quotient !== 32'd142 || o_remainder !== 32'd6 || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_second_result q=%0d r=%0d valid=%b want 142/6/1", o_quotient, o_remainder, o_valid);
    end
    take_result();
  endtask

  task automatic test_flush();
    logic [31:0] q, r;
    int lat, bn, seen;
    i_valid    = 1'b1;
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    vectors++; if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy busy=%b in_ready=%b valid=%b want 0/1/0", o_busy, o_in_ready, o_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end

    run_div(32'd1000, 32'd7, q, r, lat, bn);
    vectors++; if (q !== 32'd142 || r !== 32'd6) begin
      miscompares++; $display("FAIL flush_pre_result q=%0d r=%0d want 142/6", q, r);
    end
    i_flush     = 1'b1;
    i_out_ready = 1'b1;
    i_valid     = 1'b1;
    i_dividend  = 32'd9;
    i_divisor   = 32'd3;
    @(posedge clk); #1;
    i_flush     = 1'b0;
    i_out_ready = 1'b0;
    i_valid     = 1'b0;
    vectors++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_done valid=%b in_ready=%b busy=%b want 0/1/0", o_valid, o_in_ready, o_busy);
    end
    @(posedge clk); #1;
    vectors++; if (o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_no_accept busy=%b in_ready=%b want 0/1", o_busy, o_in_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] q, r;
    int lat, bn;
    i_valid    = 1'b1;
    i_dividend = 32'hFFFF_0000;
    i_divisor  = 32'd3;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL arst_flags busy=%b in_ready=%b valid=%b want 0/1/0", o_busy, o_in_ready, o_valid);
    end
    vectors++; if (o_quotient !== 32'h0 || o_remainder !== 32'h0) begin
      miscompares++; $display("FAIL arst_data q=%h r=%h want 0/0", o_quotient, o_remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(32'd1000, 32'd33, q, r, lat, bn);
    vectors++; if (q !== 32'd30 || r !== 32'd10) begin
      miscompares++; $display("FAIL arst_fresh q=%0d r=%0d want 30/10", q, r);
    end
    vectors++; if (lat !== 33 || bn !== 32) begin
      miscompares++; $display("FAIL arst_fresh_timing lat=%0d busy=%0d want 33/32", lat, bn);
    end
    take_result();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    i_flush     = 1'b0;
    i_valid     = 1'b0;
    i_out_ready = 1'b0;
    i_dividend  = '0;
    i_divisor   = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cla_divider_seq
